conv3x3_window_gen: RTL

- Consumes the pixel stream from the read side of the distributed FIFO (show-ahead, OUT_REG=0) and produces 3x3 convolution windows for the conv3x3 MAC array.
- Holds two line buffers of IMG_WIDTH pixels and one 3x3 window register.
- Emits only fully populated windows, with no padding: (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, in row-major order.

---
 rtl/conv3x3_window_gen.sv | 108 ++++++++++
 1 files changed

// File: rtl/conv3x3_window_gen.sv
// rtl/conv3x3_window_gen.sv - 3x3 sliding-window generator fed from a show-ahead FIFO
module conv3x3_window_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_clr,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic                    win_valid,
  input  logic                    win_ready,
  output logic                    win_last
);

  localparam int AW = $clog2(IMG_WIDTH);
  localparam logic [CNT_WIDTH-1:0] COL_LAST   = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST   = CNT_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [CNT_WIDTH-1:0] FIRST_FULL = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  // lb1 holds the row two above the incoming pixel, lb0 the row directly above
  logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];

  logic [8:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0]       row_q, row_d;
  logic [CNT_WIDTH-1:0]       col_q, col_d;
  logic                       valid_q, valid_d;
  logic                       last_q, last_d;

  logic                       pop;
  logic [AW-1:0]              col_idx;
  logic [DATA_WIDTH-1:0]      lb0_rd;
  logic [DATA_WIDTH-1:0]      lb1_rd;

  assign pop     = ~fifo_empty & (~valid_q | win_ready) & ~frame_clr;
  assign col_idx = col_q[AW-1:0];
  assign lb0_rd  = lb0_q[col_idx];
  assign lb1_rd  = lb1_q[col_idx];

  always_comb begin
    win_d   = win_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (frame_clr) begin
      row_d   = '0;
      col_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (pop) begin
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = fifo_rd_data;
      // Rows 0..1 carry stale line-buffer data, so only r>=2 & c>=2 is a real window
      valid_d = (row_q >= FIRST_FULL) && (col_q >= FIRST_FULL);
      last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_ONE;
      end else begin
        col_d = col_q + CNT_ONE;
      end
    end else if (win_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      win_q   <= win_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      lb1_q[col_idx] <= lb0_rd;
      lb0_q[col_idx] <= fifo_rd_data;
    end
  end

  assign fifo_rd_en = pop;
  assign win_data   = win_q;
  assign win_valid  = valid_q;
  assign win_last   = last_q;

endmodule
